// File: rtl/fft16_r4_sequencer.sv
// Frame controller for a 16-point radix-4 DIF FFT: loads 16 samples, runs two in-place
// stages of four radix-4 butterflies through an external lane group, then unloads 16 bins.
module fft16_r4_sequencer #(
    parameter int DATA_W        = 32,
    parameter bit NATURAL_ORDER = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_real,
    input  logic [DATA_W-1:0]     in_imag,
    output logic [8*DATA_W-1:0]   bf_op,
    output logic [15:0]           bf_tw_exp,
    input  logic [8*DATA_W-1:0]   bf_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_imag,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int EW = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STG1   = 2'd1,
        ST_STG2   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [EW-1:0]   buf_q [16];
    logic [EW-1:0]   buf_d [16];
    logic            out_valid_q, out_valid_d;
    logic [EW-1:0]   out_dat_q, out_dat_d;
    logic            frame_done_q, frame_done_d;
    logic [1:0]      b;

    assign b = cnt_q[1:0];

    // buf[4*k1+k2] holds X[k1+4*k2]; natural order swaps the two address digits.
    function automatic logic [3:0] unload_addr(input logic [3:0] j);
        if (NATURAL_ORDER) begin
            return {j[1:0], j[3:2]};
        end else begin
            return j;
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        out_valid_d  = out_valid_q;
        out_dat_d    = out_dat_q;
        frame_done_d = 1'b0;
        bf_op        = '0;
        bf_tw_exp    = '0;
        in_ready     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_d[cnt_q] = {in_imag, in_real};
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_STG1;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_STG1: begin
                // Read and write addresses coincide, so each butterfly updates in place.
                for (int k = 0; k < 4; k++) begin
                    bf_op[k*EW +: EW]      = buf_q[{2'(k), b}];
                    bf_tw_exp[4*k +: 4]    = 4'({2'b00, b} * 4'(k));
                    buf_d[{2'(k), b}]      = bf_res[k*EW +: EW];
                end
                cnt_d = cnt_q + 4'd1;
                if (b == 2'd3) begin
                    state_d = ST_STG2;
                    cnt_d   = 4'd0;
                end
            end
            ST_STG2: begin
                for (int k = 0; k < 4; k++) begin
                    bf_op[k*EW +: EW]  = buf_q[{b, 2'(k)}];
                    buf_d[{b, 2'(k)}]  = bf_res[k*EW +: EW];
                end
                cnt_d = cnt_q + 4'd1;
                if (b == 2'd3) begin
                    state_d = ST_UNLOAD;
                    cnt_d   = 4'd0;
                end
            end
            ST_UNLOAD: begin
                // First UNLOAD cycle prefetches bin 0 into the output register.
                if (!out_valid_q) begin
                    out_dat_d   = buf_q[unload_addr(cnt_q)];
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d      = ST_LOAD;
                        cnt_d        = 4'd0;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        out_dat_d = buf_q[unload_addr(cnt_q + 4'd1)];
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            cnt_q        <= 4'd0;
            out_valid_q  <= 1'b0;
            out_dat_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_dat_q    <= out_dat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample storage carries no reset; its contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid  = out_valid_q;
    assign out_real   = out_dat_q[DATA_W-1:0];
    assign out_imag   = out_dat_q[EW-1:DATA_W];
    assign busy       = (state_q != ST_LOAD);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft16_r4_sequencer.sv
// Bench for fft16_r4_sequencer: butterfly/rotator reference model on bf_op/bf_res,
// directed frames with hand-computed bins, backpressure, mid-frame reset, back-to-back frames.
module tb_fft16_r4_sequencer;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [W-1:0]    in_real, in_imag;
    logic            out_ready;

    logic            in_ready, out_valid, busy, frame_done;
    logic [8*W-1:0]  bf_op, bf_res;
    logic [15:0]     bf_tw_exp;
    logic [W-1:0]    out_real, out_imag;

    logic            raw_in_ready, raw_out_valid, raw_busy, raw_done;
    logic [8*W-1:0]  raw_op, raw_res;
    logic [15:0]     raw_exp;
    logic [W-1:0]    raw_real, raw_imag;

    int checks   = 0;
    int failures = 0;

    int          xr [16];
    int          xi [16];
    logic [63:0] got [16];
    logic [63:0] got_raw [16];
    logic [63:0] exp_b [16];

    always #5 clk = ~clk;

    // Reference radix-4 butterfly (halving) followed by the W16^exp rotator, rounded to nearest.
    function automatic logic [8*W-1:0] bf_model(input logic [8*W-1:0] op, input logic [15:0] e);
        longint r [4];
        longint i [4];
        longint yr [4];
        longint yi [4];
        logic [8*W-1:0] res;
        real ang, c, s;
        res = '0;
        for (int m = 0; m < 4; m++) begin
            r[m] = longint'($signed(op[m*2*W +: W]));
            i[m] = longint'($signed(op[m*2*W+W +: W]));
        end
        yr[0] = r[0] + r[1] + r[2] + r[3];  yi[0] = i[0] + i[1] + i[2] + i[3];
        yr[1] = r[0] + i[1] - r[2] - i[3];  yi[1] = i[0] - r[1] - i[2] + r[3];
        yr[2] = r[0] - r[1] + r[2] - r[3];  yi[2] = i[0] - i[1] + i[2] - i[3];
        yr[3] = r[0] - i[1] - r[2] + i[3];  yi[3] = i[0] + r[1] - i[2] - r[3];
        for (int k = 0; k < 4; k++) begin
            yr[k] = yr[k] >>> 1;
            yi[k] = yi[k] >>> 1;
            ang = 2.0 * 3.14159265358979 * real'(e[4*k +: 4]) / 16.0;
            c = $cos(ang);
            s = $sin(ang);
            res[k*2*W +: W]   = W'($rtoi($floor(real'(yr[k]) * c + real'(yi[k]) * s + 0.5)));
            res[k*2*W+W +: W] = W'($rtoi($floor(real'(yi[k]) * c - real'(yr[k]) * s + 0.5)));
        end
        return res;
    endfunction

    assign bf_res  = bf_model(bf_op, bf_tw_exp);
    assign raw_res = bf_model(raw_op, raw_exp);

    fft16_r4_sequencer #(.DATA_W(W), .NATURAL_ORDER(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .bf_op(bf_op), .bf_tw_exp(bf_tw_exp),
        .bf_res(bf_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .busy(busy), .frame_done(frame_done)
    );

    fft16_r4_sequencer #(.DATA_W(W), .NATURAL_ORDER(1'b0)) u_dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(raw_in_ready),
        .in_real(in_real), .in_imag(in_imag), .bf_op(raw_op), .bf_tw_exp(raw_exp),
        .bf_res(raw_res), .out_valid(raw_out_valid), .out_ready(out_ready),
        .out_real(raw_real), .out_imag(raw_imag), .busy(raw_busy), .frame_done(raw_done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge following the 16th accept.
    task automatic load_frame(input bit hold);
        int to = 0;
        for (int s = 0; s < 16; s++) begin
            int n;
            n = 0;
            in_valid = 1'b1;
            in_real  = W'(xr[s]);
            in_imag  = W'(xi[s]);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) to++;
            @(negedge clk);
        end
        if (hold) begin
            in_real = W'(xr[0]);
            in_imag = W'(xi[0]);
        end else begin
            in_valid = 1'b0;
        end
        check("load_timeouts", 64'(to), 64'd0);
    endtask

    task automatic unload(input int pct);
        int          j = 0;
        int          guard = 0;
        int          bad = 0;
        bit          stalled = 1'b0;
        logic [63:0] held = '0;
        while (j < 16 && guard < 3000) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if ({raw_in_ready, raw_busy, raw_done, raw_out_valid} !==
                {in_ready, busy, frame_done, out_valid}) bad++;
            if (out_valid) begin
                if (in_ready || !busy) bad++;
                if (stalled) check("stall_hold", {out_real, out_imag}, held);
                if (out_ready) begin
                    got[j]     = {out_real, out_imag};
                    got_raw[j] = {raw_real, raw_imag};
                    j++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {out_real, out_imag};
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("unload_count", 64'(j), 64'd16);
        check("unload_status_bad", 64'(bad), 64'd0);
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic set_frame(input int kind);
        for (int s = 0; s < 16; s++) begin
            xi[s] = 0;
            case (kind)
                0: xr[s] = (s == 0) ? 4 : 0;
                1: xr[s] = 8;
                default: xr[s] = (s == 1) ? 4096 : 0;
            endcase
        end
    endtask

    // Expected natural-order bins for each frame kind.
    task automatic set_expect(input int kind);
        int br [4];
        int bi [4];
        int er, ei, t;
        br = '{1024, 946, 724, 392};
        bi = '{0, -392, -724, -946};
        for (int k = 0; k < 16; k++) begin
            case (kind)
                0: begin er = 1; ei = 0; end
                1: begin er = (k == 0) ? 32 : 0; ei = 0; end
                default: begin
                    er = br[k % 4];
                    ei = bi[k % 4];
                    for (int q = 0; q < k / 4; q++) begin
                        t = er; er = ei; ei = -t;
                    end
                end
            endcase
            exp_b[k] = {W'(er), W'(ei)};
        end
    endtask

    task automatic check_bins(input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_bin%0d", tag, k), got[k], exp_b[k]);
        end
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_bf_op_any", 64'(|bf_op), 64'd0);
        check("rst_bf_tw_exp", 64'(bf_tw_exp), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Impulse, with latency and frame_done width checks.
        set_frame(0); set_expect(0);
        load_frame(1'b0);
        check("busy_after_load", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd9);
        unload(100);
        check_bins("impulse");
        @(negedge clk);
        check("frame_done_width", 64'(frame_done), 64'd0);

        // DC with twiddle exponent sequence.
        set_frame(1); set_expect(1);
        load_frame(1'b0);
        check("exp_b0", 64'(bf_tw_exp), 64'h0000);
        @(negedge clk);
        check("exp_b1", 64'(bf_tw_exp), 64'h3210);
        @(negedge clk);
        check("exp_b2", 64'(bf_tw_exp), 64'h6420);
        @(negedge clk);
        check("exp_b3", 64'(bf_tw_exp), 64'h9630);
        @(negedge clk);
        check("exp_stg2", 64'(bf_tw_exp), 64'h0000);
        unload(100);
        check_bins("dc");

        // Shifted impulse under backpressure; raw instance must emit buffer order.
        set_frame(2); set_expect(2);
        load_frame(1'b0);
        unload(30);
        check_bins("shift");
        for (int j = 0; j < 16; j++) begin
            check($sformatf("raw_pos%0d", j), got_raw[j], exp_b[(j >> 2) | ((j & 3) << 2)]);
        end

        // Reset while in STG2 aborts the frame.
        set_frame(0);
        load_frame(1'b0);
        repeat (5) @(negedge clk);
        check("busy_in_stg2", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (frame_done || out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        set_frame(1); set_expect(1);
        load_frame(1'b0);
        unload(100);
        check_bins("post_rst");

        // Back-to-back impulse frames with in_valid held high throughout.
        set_frame(0); set_expect(0);
        load_frame(1'b1);
        check("b2b_in_ready_drop", 64'(in_ready), 64'd0);
        unload(100);
        check("b2b_frame1_bin0", got[0], exp_b[0]);
        load_frame(1'b0);
        unload(100);
        check_bins("b2b_frame2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
